crc16_t: RTL and testbench
==========================

CRC16_T -- requirements
Module: crc16_t

Interface
REQ-001 SHALL have ports i_crc16_t_clk (in, 1, sole clock) and i_crc16_t_rst_n (in, 1); one clock, reset asynchronous and active-low.
REQ-002 SHALL have link-side inputs i_crc16_t_tx_lt_sop, i_crc16_t_tx_lt_eop, i_crc16_t_tx_lt_valid (in, 1 each) and i_crc16_t_tx_lt_data (in, 8), carrying a DATAx PID byte followed by 0..1024 payload bytes.
REQ-003 SHALL have i_crc16_t_tx_lt_cancle (in, 1), an abort of the current packet.
REQ-004 SHALL have o_crc16_t_tx_lt_ready (out, 1), the link-side accept.
REQ-005 SHALL have i_crc16_t_tx_data_on (in, 1), the link-control permission to start a data packet.
REQ-006 SHALL have PHY-side outputs o_crc16_t_tx_lp_sop, o_crc16_t_tx_lp_eop, o_crc16_t_tx_lp_valid (out, 1 each), o_crc16_t_tx_lp_data (out, 8) and o_crc16_t_tx_lp_cancle (out, 1), with PHY accept i_crc16_t_tx_lp_ready (in, 1).
REQ-007 SHALL have o_crc16_t_tx_lp_eop_en (out, 1), a one-cycle pulse when the last CRC byte is accepted by the PHY.
REQ-008 SHALL have o_crc16_t_len_err (out, 1), a one-cycle pulse on payload overflow.
REQ-009 SHALL have parameter MAX_LEN, default 1024, the maximum payload byte count.

Function
REQ-010 SHALL implement a state machine with states IDLE, PID, DATA, CRC_LO and CRC_HI.
REQ-011 IDLE: lt_ready=0 unless data_on=1; a byte with lt_valid & lt_sop & lt_ready SHALL be taken as the PID byte, and the state SHALL move to DATA, or to CRC_LO if lt_eop is also set.
REQ-012 While data_on=0 in IDLE, lt_ready SHALL be 0 and lt_sop SHALL be ignored.
REQ-013 The output SHALL be a single register stage: a link byte is accepted when lt_valid & lt_ready, and lt_ready = (state is IDLE/PID/DATA) & (!lp_valid | lp_ready).
REQ-014 An accepted byte SHALL appear on lp_data with lp_valid=1 on the next cycle (latency 1).
REQ-015 lp_data/sop/eop SHALL be held stable until lp_valid & lp_ready.
REQ-016 lp_sop SHALL be 1 only on the PID byte.
REQ-017 lp_eop SHALL be 1 only on the CRC high byte.
REQ-018 The CRC SHALL use the USB CRC16: poly 0x8005, init 0xFFFF at each sop, payload bytes processed LSB-first, PID excluded, result bit-reversed and inverted.
REQ-019 The CRC SHALL be sent low byte (CRC_LO) then high byte (CRC_HI), and the CRC SHALL update only on accepted payload bytes.
REQ-020 DATA: on an accepted byte with lt_eop=1, the state SHALL go to CRC_LO.
REQ-021 In CRC_LO/CRC_HI, each CRC byte SHALL be loaded when the output register is free; after the CRC_HI byte is accepted by the PHY, lp_eop_en SHALL pulse and the state SHALL return to IDLE.
REQ-022 An lt_sop in PID/DATA SHALL be treated as data (no restart).
REQ-023 An 11-bit payload counter SHALL be kept; an accepted byte that would make the count exceed MAX_LEN SHALL pulse len_err and act as a cancel.
REQ-024 On cancel in any non-IDLE state:
- lp_cancle SHALL pulse for 1 cycle;
- lp_valid SHALL clear the same cycle;
- the state SHALL return to IDLE;
- lp_eop_en SHALL NOT pulse.
REQ-025 Cancel in IDLE SHALL be ignored, and cancel SHALL have priority over a simultaneous byte accept.
REQ-026 lp_ready held 0 SHALL stall without loss or duplication, in any state.

Reset
REQ-027 On reset assertion, all outputs SHALL be 0, the state SHALL be IDLE, CRC = 0xFFFF and the count = 0, asynchronously.
REQ-028 A reset mid-packet SHALL discard the packet with no lp_cancle pulse.

Structure
REQ-029 A shared package SHALL hold the state encoding, CRC16_POLY=0x8005, CRC16_INIT=0xFFFF and the DATA0/DATA1/DATA2/MDATA PID codes.
REQ-030 The byte-wide CRC16 next-state function SHALL be a sub-module crc16_byte (combinational, crc_in, data_in -> crc_out).

Verification
REQ-031 The bench SHALL cover: zero-length packet, PID 0xC3 with sop & eop, lp_ready=1 -> output C3, 00, 00; sop on C3, eop on the last 00; lp_eop_en pulses once.
REQ-032 The bench SHALL cover: PID 0xC3 plus payload 00 01 02 03 -> the 2 CRC bytes equal the bench's bit-serial model, and the receive-side CRC over payload+CRC gives residual 0x800D.
REQ-033 The bench SHALL cover: 8-byte payload with lp_ready toggling randomly -> the byte sequence is identical to the lp_ready=1 run, with no duplicates and no drops.
REQ-034 The bench SHALL cover: cancel asserted on the 3rd payload byte -> lp_cancle pulses 1 cycle, no lp_eop, no eop_en; the next packet's CRC is correct (init 0xFFFF).
REQ-035 The bench SHALL cover: 1025 payload bytes with MAX_LEN=1024 -> len_err and lp_cancle on byte 1025; 1024 bytes -> normal completion.
REQ-036 The bench SHALL cover: data_on=0 with sop valid for 10 cycles -> lt_ready=0 throughout; raising data_on -> PID accepted the next cycle.

Source files
------------

// File: rtl/crc16_t_pkg.sv
// crc16_t_pkg: shared FSM encoding, USB CRC16 constants, PID codes and output register type
package crc16_t_pkg;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PID    = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CRC_LO = 3'd3;
  localparam logic [2:0] S_CRC_HI = 3'd4;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_DATA2 = 8'h87;
  localparam logic [7:0] PID_MDATA = 8'h0F;
  typedef struct packed {
    logic       valid;
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } lp_reg_t;
  // transmitted CRC is the register bit-reversed and inverted
  function automatic logic [15:0] crc16_final(input logic [15:0] c);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = ~c[15-i];
    return r;
  endfunction
endpackage

// File: rtl/crc16_byte.sv
// crc16_byte: combinational USB CRC16 update over one byte, bits taken LSB-first
// ports: crc_in current register, data_in payload byte, crc_out next register
module crc16_byte
  import crc16_t_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);
  logic [15:0] c;
  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) c = {c[14:0], 1'b0} ^ ((c[15] ^ data_in[i]) ? CRC16_POLY : 16'h0000);
  end
  assign crc_out = c;
endmodule

// File: rtl/crc16_t.sv
// crc16_t: USB data-packet transmitter stage appending CRC16 behind a single output register
// ports: clk/rst_n (async active-low); lt_* link-side PID+payload in with ready/cancel;
//        data_on start permission; lp_* PHY-side bytes out with ready/cancel;
//        lp_eop_en pulses when the CRC high byte is taken; len_err pulses on payload overflow
module crc16_t
  import crc16_t_pkg::*;
#(
  parameter int MAX_LEN = 1024
) (
  input  logic       i_crc16_t_clk,
  input  logic       i_crc16_t_rst_n,
  input  logic       i_crc16_t_tx_lt_sop,
  input  logic       i_crc16_t_tx_lt_eop,
  input  logic       i_crc16_t_tx_lt_valid,
  input  logic [7:0] i_crc16_t_tx_lt_data,
  input  logic       i_crc16_t_tx_lt_cancle,
  output logic       o_crc16_t_tx_lt_ready,
  input  logic       i_crc16_t_tx_data_on,
  output logic       o_crc16_t_tx_lp_sop,
  output logic       o_crc16_t_tx_lp_eop,
  output logic       o_crc16_t_tx_lp_valid,
  output logic [7:0] o_crc16_t_tx_lp_data,
  output logic       o_crc16_t_tx_lp_cancle,
  input  logic       i_crc16_t_tx_lp_ready,
  output logic       o_crc16_t_tx_lp_eop_en,
  output logic       o_crc16_t_len_err
);
  logic [2:0] state_q, state_d;
  logic [15:0] crc_q, crc_d, crc_nx, crc_fin;
  logic [10:0] cnt_q, cnt_d;
  lp_reg_t lp_q, lp_d;
  logic cancle_q, cancle_d, eop_en_q, eop_en_d, len_err_q, len_err_d;
  logic out_free, in_pkt, accept, ovf, cancel;
  assign out_free = !lp_q.valid | i_crc16_t_tx_lp_ready;
  assign in_pkt = (state_q == S_PID) | (state_q == S_DATA);
  assign o_crc16_t_tx_lt_ready = (in_pkt | ((state_q == S_IDLE) & i_crc16_t_tx_data_on)) & out_free;
  assign accept = i_crc16_t_tx_lt_valid & o_crc16_t_tx_lt_ready;
  assign ovf = accept & in_pkt & (cnt_q == 11'(MAX_LEN));
  // overflow aborts the packet exactly like a link cancel, and wins over the byte
  assign cancel = (state_q != S_IDLE) & (i_crc16_t_tx_lt_cancle | ovf);
  assign crc_fin = crc16_final(crc_q);
  crc16_byte u_crc (
    .crc_in (crc_q),
    .data_in(i_crc16_t_tx_lt_data),
    .crc_out(crc_nx)
  );
  always_comb begin
    state_d = state_q;
    crc_d = crc_q;
    cnt_d = cnt_q;
    lp_d = (lp_q.valid & i_crc16_t_tx_lp_ready) ? '0 : lp_q;
    cancle_d = 1'b0;
    eop_en_d = 1'b0;
    len_err_d = ovf;
    if (cancel) begin
      state_d = S_IDLE;
      crc_d = CRC16_INIT;
      cnt_d = '0;
      lp_d = '0;
      cancle_d = 1'b1;
    end else begin
      if (state_q == S_IDLE && accept && i_crc16_t_tx_lt_sop) begin
        lp_d = {1'b1, 1'b1, 1'b0, i_crc16_t_tx_lt_data};
        crc_d = CRC16_INIT;
        cnt_d = '0;
        state_d = i_crc16_t_tx_lt_eop ? S_CRC_LO : S_DATA;
      end
      if (in_pkt && accept) begin
        lp_d = {1'b1, 1'b0, 1'b0, i_crc16_t_tx_lt_data};
        crc_d = crc_nx;
        cnt_d = cnt_q + 11'd1;
        state_d = i_crc16_t_tx_lt_eop ? S_CRC_LO : S_DATA;
      end
      if (state_q == S_CRC_LO && out_free) begin
        lp_d = {1'b1, 1'b0, 1'b0, crc_fin[7:0]};
        state_d = S_CRC_HI;
      end
      // CRC_HI first loads the high byte (eop set), then waits for the PHY to take it
      if (state_q == S_CRC_HI && !lp_q.eop && out_free) lp_d = {1'b1, 1'b0, 1'b1, crc_fin[15:8]};
      if (state_q == S_CRC_HI && lp_q.eop && lp_q.valid && i_crc16_t_tx_lp_ready) begin
        state_d = S_IDLE;
        eop_en_d = 1'b1;
      end
      if (state_q > S_CRC_HI) state_d = S_IDLE;
    end
  end
  always_ff @(posedge i_crc16_t_clk or negedge i_crc16_t_rst_n) begin
    if (!i_crc16_t_rst_n) begin
      state_q <= S_IDLE;
      crc_q <= CRC16_INIT;
      cnt_q <= '0;
      lp_q <= '0;
      cancle_q <= 1'b0;
      eop_en_q <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q <= crc_d;
      cnt_q <= cnt_d;
      lp_q <= lp_d;
      cancle_q <= cancle_d;
      eop_en_q <= eop_en_d;
      len_err_q <= len_err_d;
    end
  end
  assign o_crc16_t_tx_lp_valid = lp_q.valid;
  assign o_crc16_t_tx_lp_sop = lp_q.sop;
  assign o_crc16_t_tx_lp_eop = lp_q.eop;
  assign o_crc16_t_tx_lp_data = lp_q.data;
  assign o_crc16_t_tx_lp_cancle = cancle_q;
  assign o_crc16_t_tx_lp_eop_en = eop_en_q;
  assign o_crc16_t_len_err = len_err_q;
endmodule

// File: tb/tb_crc16_t.sv
// tb_crc16_t: scoreboard bench for crc16_t with a reflected bit-serial CRC model
module tb_crc16_t;
  localparam int MAXL = 1024;
  logic clk = 0, rst_n = 0;
  logic lt_sop = 0, lt_eop = 0, lt_valid = 0, lt_cancle = 0, data_on = 0, lp_ready = 1;
  logic [7:0] lt_data = 0;
  logic lt_ready, lp_sop, lp_eop, lp_valid, lp_cancle, eop_en, len_err;
  logic [7:0] lp_data;
  int evals = 0, fails = 0, eop_en_cnt = 0, cancle_cnt = 0, len_err_cnt = 0, eop_cnt = 0;
  logic prev_c = 0, prev_e = 0, held = 0, rand_rdy = 0;
  logic [9:0] hv;
  logic [9:0] exp_q[$], obs_q[$], run_a[$];
  logic [7:0] pl[0:1099];

  crc16_t dut (
    .i_crc16_t_clk(clk), .i_crc16_t_rst_n(rst_n),
    .i_crc16_t_tx_lt_sop(lt_sop), .i_crc16_t_tx_lt_eop(lt_eop),
    .i_crc16_t_tx_lt_valid(lt_valid), .i_crc16_t_tx_lt_data(lt_data),
    .i_crc16_t_tx_lt_cancle(lt_cancle), .o_crc16_t_tx_lt_ready(lt_ready),
    .i_crc16_t_tx_data_on(data_on),
    .o_crc16_t_tx_lp_sop(lp_sop), .o_crc16_t_tx_lp_eop(lp_eop),
    .o_crc16_t_tx_lp_valid(lp_valid), .o_crc16_t_tx_lp_data(lp_data),
    .o_crc16_t_tx_lp_cancle(lp_cancle), .i_crc16_t_tx_lp_ready(lp_ready),
    .o_crc16_t_tx_lp_eop_en(eop_en), .o_crc16_t_len_err(len_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    evals++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_model(input int n);
    logic [15:0] c = 16'hFFFF;
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      b = pl[k];
      for (int i = 0; i < 8; i++) begin
        if (c[0] ^ b[i]) c = (c >> 1) ^ 16'hA001;
        else c = c >> 1;
      end
    end
    return ~c;
  endfunction

  always @(posedge clk) begin
    #1;
    lp_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) if (rst_n) begin
    if (held) chk("stall_hold", {22'd0, lp_valid, lp_sop, lp_eop, lp_data}, {22'd0, 1'b1, hv});
    held = lp_valid && !lp_ready;
    hv = {lp_sop, lp_eop, lp_data};
    if (lp_valid && lp_ready) begin
      obs_q.push_back({lp_sop, lp_eop, lp_data});
      if (lp_eop) eop_cnt++;
      chk("unexpected_byte", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("lp_byte", {22'd0, lp_sop, lp_eop, lp_data}, {22'd0, exp_q.pop_front()});
    end
    if (lp_cancle) begin
      cancle_cnt++;
      chk("cancel_width", prev_c, 0);
      chk("cancel_valid", lp_valid, 0);
    end
    if (eop_en) begin
      eop_en_cnt++;
      chk("eop_en_width", prev_e, 0);
    end
    if (len_err) len_err_cnt++;
    prev_c = lp_cancle;
    prev_e = eop_en;
  end

  task automatic push(input logic s, input logic e, input logic [7:0] d);
    exp_q.push_back({s, e, d});
  endtask

  task automatic drive_byte(input logic s, input logic e, input logic [7:0] d, input logic c);
    int t = 0;
    lt_valid = 1; lt_sop = s; lt_eop = e; lt_data = d; lt_cancle = c;
    @(negedge clk);
    while (!lt_ready && t < 200) begin
      @(posedge clk); #1;
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("lt_ready_timeout", t, 0);
    @(posedge clk); #1;
    lt_valid = 0; lt_sop = 0; lt_eop = 0; lt_cancle = 0;
  endtask

  task automatic send_pkt(input logic [7:0] pid, input int n, input int cancel_at);
    logic [15:0] c;
    push(1, 0, pid);
    drive_byte(1, n == 0, pid, 0);
    for (int k = 0; k < n; k++) begin
      if (k == cancel_at) begin
        drive_byte(0, k == n - 1, pl[k], 1);
        return;
      end
      if (k >= MAXL) begin
        drive_byte(0, 1, pl[k], 0);
        return;
      end
      push(0, 0, pl[k]);
      drive_byte(0, k == n - 1, pl[k], 0);
    end
    c = crc_model(n);
    push(0, 0, c[7:0]);
    push(0, 1, c[15:8]);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] r;
    logic [9:0] w;
    logic [7:0] b;
    int e0, c0, l0, q0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {lp_sop, lp_eop, lp_valid, lp_data, lp_cancle, eop_en, len_err, lt_ready}, 0);
    @(posedge clk); #1;
    rst_n = 1; data_on = 1;
    repeat (2) @(posedge clk); #1;
    // zero-length packet: C3, 00, 00
    obs_q.delete();
    send_pkt(8'hC3, 0, -1);
    wait_drain();
    chk("zero_len_bytes", obs_q.size(), 3);
    chk("zero_len_eop_en", eop_en_cnt, 1);
    // 4-byte payload, receive-side residual
    for (int i = 0; i < 4; i++) pl[i] = 8'(i);
    obs_q.delete();
    send_pkt(8'hC3, 4, -1);
    wait_drain();
    chk("p4_bytes", obs_q.size(), 7);
    r = 16'hFFFF;
    for (int j = 1; j < obs_q.size(); j++) begin
      w = obs_q[j];
      b = w[7:0];
      for (int i = 0; i < 8; i++) r = {r[14:0], 1'b0} ^ ((r[15] ^ b[i]) ? 16'h8005 : 16'h0000);
    end
    chk("residual", r, 16'h800D);
    chk("p4_eop_en", eop_en_cnt, 2);
    // 8-byte payload: ready=1 run vs random-ready run
    for (int i = 0; i < 8; i++) pl[i] = 8'($urandom);
    obs_q.delete();
    send_pkt(8'h4B, 8, -1);
    wait_drain();
    run_a = obs_q;
    obs_q.delete();
    rand_rdy = 1;
    send_pkt(8'h4B, 8, -1);
    wait_drain();
    rand_rdy = 0;
    chk("rand_len", obs_q.size(), run_a.size());
    for (int i = 0; i < run_a.size() && i < obs_q.size(); i++) chk("rand_seq", obs_q[i], run_a[i]);
    chk("rand_eop_en", eop_en_cnt, 4);
    repeat (2) @(posedge clk); #1;
    // cancel on 3rd payload byte, then a clean packet
    e0 = eop_en_cnt; c0 = cancle_cnt; q0 = eop_cnt;
    for (int i = 0; i < 5; i++) pl[i] = 8'(8'h10 + i);
    send_pkt(8'hC3, 5, 2);
    wait_drain();
    chk("cancel_pulse", cancle_cnt, c0 + 1);
    chk("cancel_no_eop_en", eop_en_cnt, e0);
    chk("cancel_no_eop", eop_cnt, q0);
    for (int i = 0; i < 3; i++) pl[i] = 8'(8'hA0 + i);
    send_pkt(8'h87, 3, -1);
    wait_drain();
    chk("after_cancel_eop_en", eop_en_cnt, e0 + 1);
    // overflow: 1025 bytes, then exactly 1024
    for (int i = 0; i < 1100; i++) pl[i] = 8'($urandom);
    e0 = eop_en_cnt; c0 = cancle_cnt; l0 = len_err_cnt;
    send_pkt(8'hC3, MAXL + 1, -1);
    wait_drain();
    chk("ovf_len_err", len_err_cnt, l0 + 1);
    chk("ovf_cancel", cancle_cnt, c0 + 1);
    chk("ovf_no_eop_en", eop_en_cnt, e0);
    send_pkt(8'h0F, MAXL, -1);
    wait_drain();
    chk("max_len_eop_en", eop_en_cnt, e0 + 1);
    chk("max_len_no_err", len_err_cnt, l0 + 1);
    // data_on gating
    data_on = 0;
    lt_valid = 1; lt_sop = 1; lt_eop = 1; lt_data = 8'hC3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("data_off_ready", lt_ready, 0);
      @(posedge clk); #1;
    end
    data_on = 1;
    push(1, 0, 8'hC3); push(0, 0, 8'h00); push(0, 1, 8'h00);
    @(negedge clk);
    chk("data_on_ready", lt_ready, 1);
    @(posedge clk); #1;
    lt_valid = 0; lt_sop = 0; lt_eop = 0;
    @(negedge clk);
    chk("data_on_pid_out", {lp_valid, lp_sop, lp_data}, {1'b1, 1'b1, 8'hC3});
    wait_drain();
    chk("data_on_eop_en", eop_en_cnt, e0 + 2);
    $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
    $finish;
  end
endmodule
